// File: rtl/pim_dma_pkg.sv
// rtl/pim_dma_pkg.sv - shared types and constants for the PIM DMA engine
//
// Contents:
//   dma_state_e    : engine FSM states
//   DMA_M2P        : funct3 for memory -> PIM transfers
//   DMA_P2M        : funct3 for PIM -> memory transfers
//   DMA_WORD_BYTES : bytes moved per beat
//   DMA_SIZE_W     : width of the byte-length field of a command
//   DMA_CNT_W      : width of the derived word counter
package pim_dma_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      M2P_RD  = 3'd1,
      M2P_WR  = 3'd2,
      P2M_RD  = 3'd3,
      P2M_CAP = 3'd4,
      P2M_WR  = 3'd5,
      DONE    = 3'd6
   } dma_state_e;

   localparam logic [2:0] DMA_M2P = 3'b000;
   localparam logic [2:0] DMA_P2M = 3'b001;

   localparam int DMA_WORD_BYTES = 4;
   localparam int DMA_SIZE_W     = 13;
   localparam int DMA_CNT_W      = DMA_SIZE_W - 2;

endpackage

// File: rtl/pim_dma_engine.sv
// rtl/pim_dma_engine.sv - DMA responder moving words between data memory and PIM units
//
// Ports:
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_dma_en, i_dma_funct3,
//   i_dma_sel_pim, i_dma_size,
//   i_dma_mem_addr            : one-cycle command from the core's EX stage
//   o_dma_busy/done/err       : pipeline stall, completion pulse, illegal-command pulse
//   o_req_dmem, i_gnt_dmem    : shared data-memory port handshake
//   o_data_*, i_data_rd_data  : data-memory access signals
//   o_pim_*, i_pim_rd_data    : PIM unit access signals
module pim_dma_engine
   import pim_dma_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int PIM_AW = 11
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_dma_en,
   input  logic [2:0]            i_dma_funct3,
   input  logic [3:0]            i_dma_sel_pim,
   input  logic [DMA_SIZE_W-1:0] i_dma_size,
   input  logic [XLEN-1:0]       i_dma_mem_addr,
   output logic                  o_dma_busy,
   output logic                  o_dma_done,
   output logic                  o_dma_err,
   output logic                  o_req_dmem,
   input  logic                  i_gnt_dmem,
   output logic [XLEN-1:0]       o_data_addr,
   input  logic [XLEN-1:0]       i_data_rd_data,
   output logic [XLEN-1:0]       o_data_wr_data,
   output logic [3:0]            o_data_size,
   output logic                  o_data_read,
   output logic                  o_data_write,
   output logic [3:0]            o_pim_sel,
   output logic [PIM_AW-1:0]     o_pim_addr,
   output logic [XLEN-1:0]       o_pim_wr_data,
   output logic                  o_pim_write,
   output logic                  o_pim_read,
   input  logic [XLEN-1:0]       i_pim_rd_data
);

   dma_state_e           state_q, state_d;
   logic [XLEN-1:0]      mem_addr_q, mem_addr_d;
   logic [PIM_AW-1:0]    pim_addr_q, pim_addr_d;
   logic [DMA_CNT_W-1:0] count_q, count_d;
   logic [3:0]           sel_q, sel_d;
   logic [XLEN-1:0]      buf_q, buf_d;
   logic                 busy_q, busy_d;
   logic                 err_q, err_d;

   // Byte-offset bits of size and address are dropped by design.
   logic unused_ok;
   assign unused_ok = ^{i_dma_size[1:0], i_dma_mem_addr[1:0]};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         mem_addr_q <= '0;
         pim_addr_q <= '0;
         count_q    <= '0;
         sel_q      <= '0;
         buf_q      <= '0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         mem_addr_q <= mem_addr_d;
         pim_addr_q <= pim_addr_d;
         count_q    <= count_d;
         sel_q      <= sel_d;
         buf_q      <= buf_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      mem_addr_d    = mem_addr_q;
      pim_addr_d    = pim_addr_q;
      count_d       = count_q;
      sel_d         = sel_q;
      buf_d         = buf_q;
      err_d         = 1'b0;
      o_req_dmem    = 1'b0;
      o_data_read   = 1'b0;
      o_data_write  = 1'b0;
      o_data_size   = 4'b0000;
      o_pim_write   = 1'b0;
      o_pim_read    = 1'b0;
      o_pim_wr_data = '0;
      o_dma_done    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (i_dma_en) begin
               if (i_dma_funct3 == DMA_M2P || i_dma_funct3 == DMA_P2M) begin
                  sel_d      = i_dma_sel_pim;
                  mem_addr_d = {i_dma_mem_addr[XLEN-1:2], 2'b00};
                  count_d    = i_dma_size[DMA_SIZE_W-1:2];
                  pim_addr_d = '0;
                  if (i_dma_size[DMA_SIZE_W-1:2] == '0) begin
                     state_d = DONE;
                  end else if (i_dma_funct3 == DMA_M2P) begin
                     state_d = M2P_RD;
                  end else begin
                     state_d = P2M_RD;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         M2P_RD: begin
            o_req_dmem  = 1'b1;
            o_data_read = 1'b1;
            o_data_size = 4'b1111;
            if (i_gnt_dmem) begin
               state_d = M2P_WR;
            end
         end

         // Read data returns the cycle after the grant, so it is forwarded
         // straight to the PIM without an intermediate register.
         M2P_WR: begin
            o_pim_write   = 1'b1;
            o_pim_wr_data = i_data_rd_data;
            mem_addr_d    = mem_addr_q + XLEN'(DMA_WORD_BYTES);
            pim_addr_d    = pim_addr_q + PIM_AW'(1);
            count_d       = count_q - DMA_CNT_W'(1);
            state_d       = (count_q == DMA_CNT_W'(1)) ? DONE : M2P_RD;
         end

         P2M_RD: begin
            o_pim_read = 1'b1;
            state_d    = P2M_CAP;
         end

         P2M_CAP: begin
            buf_d   = i_pim_rd_data;
            state_d = P2M_WR;
         end

         P2M_WR: begin
            o_req_dmem   = 1'b1;
            o_data_write = 1'b1;
            o_data_size  = 4'b1111;
            if (i_gnt_dmem) begin
               mem_addr_d = mem_addr_q + XLEN'(DMA_WORD_BYTES);
               pim_addr_d = pim_addr_q + PIM_AW'(1);
               count_d    = count_q - DMA_CNT_W'(1);
               state_d    = (count_q == DMA_CNT_W'(1)) ? DONE : P2M_RD;
            end
         end

         DONE: begin
            o_dma_done = 1'b1;
            state_d    = IDLE;
         end

         default: state_d = IDLE;
      endcase

      // Registered so busy covers exactly the cycles spent outside IDLE.
      busy_d = (state_d != IDLE);
   end

   assign o_dma_busy     = busy_q;
   assign o_dma_err      = err_q;
   assign o_data_addr    = mem_addr_q;
   assign o_data_wr_data = buf_q;
   assign o_pim_sel      = sel_q;
   assign o_pim_addr     = pim_addr_q;

endmodule

// File: tb/tb_pim_dma_engine.sv
// tb/tb_pim_dma_engine.sv - self-checking bench for pim_dma_engine
module tb_pim_dma_engine;

   localparam int XLEN   = 32;
   localparam int PIM_AW = 11;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  sel;
   } txn_t;

   logic              i_clk = 1'b0;
   logic              i_rst_n;
   logic              i_dma_en;
   logic [2:0]        i_dma_funct3;
   logic [3:0]        i_dma_sel_pim;
   logic [12:0]       i_dma_size;
   logic [31:0]       i_dma_mem_addr;
   logic              o_dma_busy, o_dma_done, o_dma_err;
   logic              o_req_dmem;
   logic              i_gnt_dmem = 1'b0;
   logic [31:0]       o_data_addr;
   logic [31:0]       i_data_rd_data = 32'h0;
   logic [31:0]       o_data_wr_data;
   logic [3:0]        o_data_size;
   logic              o_data_read, o_data_write;
   logic [3:0]        o_pim_sel;
   logic [PIM_AW-1:0] o_pim_addr;
   logic [31:0]       o_pim_wr_data;
   logic              o_pim_write, o_pim_read;
   logic [31:0]       i_pim_rd_data = 32'h0;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Monitor-owned observations; the stimulus side only reads them.
   int   busy_cyc = 0, done_cnt = 0, err_cnt = 0, stall_cyc = 0;
   txn_t mem_rd_q[$];
   txn_t mem_wr_q[$];
   txn_t pim_wr_q[$];
   txn_t pim_rd_q[$];

   // Stimulus-owned grant policy: 0 always grant, 1 random, 2 withhold
   // until the total stall count reaches withhold_until.
   int gnt_mode       = 0;
   int withhold_until = 0;

   int b_busy, b_done, b_err, b_stall, b_mrd, b_mwr, b_pwr, b_prd;

   pim_dma_engine #(.XLEN(XLEN), .PIM_AW(PIM_AW)) dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_dma_en       (i_dma_en),
      .i_dma_funct3   (i_dma_funct3),
      .i_dma_sel_pim  (i_dma_sel_pim),
      .i_dma_size     (i_dma_size),
      .i_dma_mem_addr (i_dma_mem_addr),
      .o_dma_busy     (o_dma_busy),
      .o_dma_done     (o_dma_done),
      .o_dma_err      (o_dma_err),
      .o_req_dmem     (o_req_dmem),
      .i_gnt_dmem     (i_gnt_dmem),
      .o_data_addr    (o_data_addr),
      .i_data_rd_data (i_data_rd_data),
      .o_data_wr_data (o_data_wr_data),
      .o_data_size    (o_data_size),
      .o_data_read    (o_data_read),
      .o_data_write   (o_data_write),
      .o_pim_sel      (o_pim_sel),
      .o_pim_addr     (o_pim_addr),
      .o_pim_wr_data  (o_pim_wr_data),
      .o_pim_write    (o_pim_write),
      .o_pim_read     (o_pim_read),
      .i_pim_rd_data  (i_pim_rd_data)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] memval(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] pimval(input logic [3:0] s, input logic [10:0] a);
      return {s, 5'b10110, a, ~a, 1'b1};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Memory/PIM responder and transaction monitor, sampling mid-cycle.
   bit          prev_wait = 0, prev_mrd = 0, prev_prd = 0, prev_rd = 0;
   logic [31:0] prev_addr = 0, prev_wdata = 0;
   always @(negedge i_clk) begin
      logic g;
      logic mrd_now;
      if (!i_rst_n) begin
         prev_wait = 0;
         prev_mrd  = 0;
         prev_prd  = 0;
         i_gnt_dmem = 1'b0;
      end else begin
         if (o_dma_busy) busy_cyc++;
         if (o_dma_done) done_cnt++;
         if (o_dma_err)  err_cnt++;
         if (o_pim_write) pim_wr_q.push_back('{32'(o_pim_addr), o_pim_wr_data, o_pim_sel});
         if (o_pim_read)  pim_rd_q.push_back('{32'(o_pim_addr), 32'h0, o_pim_sel});
         if (prev_wait) begin
            chk("req_held", 32'(o_req_dmem), 32'h1);
            chk("addr_held", o_data_addr, prev_addr);
            chk("dir_held", 32'(o_data_read), 32'(prev_rd));
            if (!prev_rd) chk("wdata_held", o_data_wr_data, prev_wdata);
         end
         if (o_req_dmem) chk("byte_en", 32'(o_data_size), 32'hF);

         case (gnt_mode)
            1:       g = 1'($urandom_range(0, 1));
            2:       g = !(o_req_dmem && stall_cyc < withhold_until);
            default: g = 1'b1;
         endcase
         i_gnt_dmem = g;
         if (o_req_dmem && !g) stall_cyc++;
         prev_wait  = o_req_dmem && !g;
         prev_addr  = o_data_addr;
         prev_wdata = o_data_wr_data;
         prev_rd    = o_data_read;

         mrd_now = o_req_dmem && o_data_read && g;
         if (mrd_now) begin
            mem_rd_q.push_back('{o_data_addr, 32'h0, 4'h0});
            i_data_rd_data = memval(o_data_addr);
         end else if (!prev_mrd) begin
            i_data_rd_data = $urandom;
         end
         if (o_req_dmem && o_data_write && g)
            mem_wr_q.push_back('{o_data_addr, o_data_wr_data, 4'h0});
         if (o_pim_read)
            i_pim_rd_data = pimval(o_pim_sel, o_pim_addr);
         else if (!prev_prd)
            i_pim_rd_data = $urandom;
         prev_mrd = mrd_now;
         prev_prd = o_pim_read;
      end
   end

   task automatic snap();
      b_busy  = busy_cyc;
      b_done  = done_cnt;
      b_err   = err_cnt;
      b_stall = stall_cyc;
      b_mrd   = mem_rd_q.size();
      b_mwr   = mem_wr_q.size();
      b_pwr   = pim_wr_q.size();
      b_prd   = pim_rd_q.size();
   endtask

   task automatic issue(input logic [2:0] f, input logic [3:0] s,
                        input logic [12:0] sz, input logic [31:0] a);
      @(posedge i_clk);
      #1;
      i_dma_en       = 1'b1;
      i_dma_funct3   = f;
      i_dma_sel_pim  = s;
      i_dma_size     = sz;
      i_dma_mem_addr = a;
      @(posedge i_clk);
      #1;
      i_dma_en       = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge i_clk);
         if (done_cnt > b_done || err_cnt > b_err) break;
      end
      repeat (3) @(posedge i_clk);
      chk("finished_in_budget", 32'(done_cnt > b_done || err_cnt > b_err), 32'h1);
   endtask

   // Expected results follow from the command alone: word k moves between
   // memory byte address base+4k and PIM word k.
   task automatic check_cmd(input string nm, input logic [2:0] f, input logic [3:0] s,
                            input logic [12:0] sz, input logic [31:0] a);
      int          n;
      logic [31:0] base;
      n    = int'(sz[12:2]);
      base = {a[31:2], 2'b00};
      if (f != 3'b000 && f != 3'b001) begin
         chk({nm, ":err"}, 32'(err_cnt - b_err), 32'd1);
         chk({nm, ":done"}, 32'(done_cnt - b_done), 32'd0);
         chk({nm, ":busy"}, 32'(busy_cyc - b_busy), 32'd0);
         n = 0;
      end else begin
         chk({nm, ":err"}, 32'(err_cnt - b_err), 32'd0);
         chk({nm, ":done"}, 32'(done_cnt - b_done), 32'd1);
         chk({nm, ":busy"}, 32'(busy_cyc - b_busy),
             32'(1 + n * ((f == 3'b000) ? 2 : 3) + (stall_cyc - b_stall)));
      end
      chk({nm, ":n_mrd"}, 32'(mem_rd_q.size() - b_mrd), (f == 3'b000) ? 32'(n) : 32'd0);
      chk({nm, ":n_pwr"}, 32'(pim_wr_q.size() - b_pwr), (f == 3'b000) ? 32'(n) : 32'd0);
      chk({nm, ":n_prd"}, 32'(pim_rd_q.size() - b_prd), (f == 3'b001) ? 32'(n) : 32'd0);
      chk({nm, ":n_mwr"}, 32'(mem_wr_q.size() - b_mwr), (f == 3'b001) ? 32'(n) : 32'd0);
      if (f == 3'b000 && mem_rd_q.size() - b_mrd == n && pim_wr_q.size() - b_pwr == n) begin
         for (int k = 0; k < n; k++) begin
            chk({nm, ":rd_addr"}, mem_rd_q[b_mrd+k].addr, base + 32'(4 * k));
            chk({nm, ":pw_addr"}, pim_wr_q[b_pwr+k].addr, 32'(k % 2048));
            chk({nm, ":pw_data"}, pim_wr_q[b_pwr+k].data, memval(base + 32'(4 * k)));
            chk({nm, ":pw_sel"}, 32'(pim_wr_q[b_pwr+k].sel), 32'(s));
         end
      end
      if (f == 3'b001 && pim_rd_q.size() - b_prd == n && mem_wr_q.size() - b_mwr == n) begin
         for (int k = 0; k < n; k++) begin
            chk({nm, ":pr_addr"}, pim_rd_q[b_prd+k].addr, 32'(k % 2048));
            chk({nm, ":pr_sel"}, 32'(pim_rd_q[b_prd+k].sel), 32'(s));
            chk({nm, ":wr_addr"}, mem_wr_q[b_mwr+k].addr, base + 32'(4 * k));
            chk({nm, ":wr_data"}, mem_wr_q[b_mwr+k].data, pimval(s, 11'(k)));
         end
      end
   endtask

   task automatic check_all_zero(input string nm);
      chk({nm, ":strobes"}, 32'({o_dma_busy, o_dma_done, o_dma_err, o_req_dmem,
                                  o_data_read, o_data_write, o_pim_write, o_pim_read}), 32'h0);
      chk({nm, ":data_addr"}, o_data_addr, 32'h0);
      chk({nm, ":data_wr"}, o_data_wr_data, 32'h0);
      chk({nm, ":data_size"}, 32'(o_data_size), 32'h0);
      chk({nm, ":pim_sel"}, 32'(o_pim_sel), 32'h0);
      chk({nm, ":pim_addr"}, 32'(o_pim_addr), 32'h0);
      chk({nm, ":pim_wr"}, o_pim_wr_data, 32'h0);
   endtask

   initial begin
      logic [2:0]  rf;
      logic [3:0]  rs;
      logic [12:0] rsz;
      logic [31:0] ra;
      i_rst_n        = 1'b0;
      i_dma_en       = 1'b0;
      i_dma_funct3   = 3'b000;
      i_dma_sel_pim  = 4'b0000;
      i_dma_size     = 13'd0;
      i_dma_mem_addr = 32'h0;
      repeat (3) @(posedge i_clk);
      #1;
      check_all_zero("reset");
      i_rst_n = 1'b1;

      // MEM->PIM, constant grant, busy 2N+1
      gnt_mode = 0;
      snap();
      issue(3'b000, 4'b0010, 13'd16, 32'h1000_0000);
      wait_done(100);
      check_cmd("m2p16", 3'b000, 4'b0010, 13'd16, 32'h1000_0000);
      chk("m2p16:busy9", 32'(busy_cyc - b_busy), 32'd9);
      chk("m2p16:pim_sel", 32'(o_pim_sel), 32'h2);

      // PIM->MEM with grant withheld 3 cycles on word 0
      gnt_mode = 2;
      snap();
      withhold_until = stall_cyc + 3;
      issue(3'b001, 4'b0100, 13'd8, 32'h2000_0040);
      wait_done(100);
      check_cmd("p2m_hold", 3'b001, 4'b0100, 13'd8, 32'h2000_0040);
      chk("p2m_hold:stalls", 32'(stall_cyc - b_stall), 32'd3);
      gnt_mode = 0;

      // zero length
      snap();
      issue(3'b000, 4'b0001, 13'd3, 32'h1000_0000);
      wait_done(50);
      check_cmd("zero", 3'b000, 4'b0001, 13'd3, 32'h1000_0000);
      chk("zero:busy1", 32'(busy_cyc - b_busy), 32'd1);

      // unaligned start address
      snap();
      issue(3'b000, 4'b1000, 13'd8, 32'h1000_0003);
      wait_done(50);
      check_cmd("unalign", 3'b000, 4'b1000, 13'd8, 32'h1000_0003);
      chk("unalign:first", mem_rd_q[b_mrd].addr, 32'h1000_0000);

      // illegal funct3
      snap();
      issue(3'b101, 4'b0010, 13'd16, 32'h1000_0000);
      wait_done(20);
      check_cmd("illegal", 3'b101, 4'b0010, 13'd16, 32'h1000_0000);

      // second strobe while busy is ignored
      snap();
      issue(3'b000, 4'b0001, 13'd16, 32'h0000_0100);
      @(posedge i_clk);
      #1;
      i_dma_en       = 1'b1;
      i_dma_funct3   = 3'b001;
      i_dma_sel_pim  = 4'b1000;
      i_dma_size     = 13'd32;
      i_dma_mem_addr = 32'h2000_0000;
      @(posedge i_clk);
      #1;
      i_dma_en = 1'b0;
      wait_done(100);
      check_cmd("busy_strobe", 3'b000, 4'b0001, 13'd16, 32'h0000_0100);

      // memory address wrap
      snap();
      issue(3'b001, 4'b0010, 13'd16, 32'hFFFF_FFF8);
      wait_done(100);
      check_cmd("addr_wrap", 3'b001, 4'b0010, 13'd16, 32'hFFFF_FFF8);

      // reset after word 2 of 8
      snap();
      issue(3'b000, 4'b0100, 13'd32, 32'h3000_0000);
      for (int i = 0; i < 100; i++) begin
         @(posedge i_clk);
         if (pim_wr_q.size() - b_pwr >= 2) break;
      end
      #2;
      i_rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      repeat (2) @(posedge i_clk);
      #1;
      chk("midreset:no_partial", 32'(pim_wr_q.size() - b_pwr), 32'd2);
      i_rst_n = 1'b1;
      snap();
      issue(3'b000, 4'b0001, 13'd16, 32'h3000_0100);
      wait_done(100);
      check_cmd("after_reset", 3'b000, 4'b0001, 13'd16, 32'h3000_0100);

      // largest non-wrapping PIM range
      snap();
      issue(3'b000, 4'b1000, 13'd8188, 32'h4000_0000);
      wait_done(5000);
      check_cmd("max2047", 3'b000, 4'b1000, 13'd8188, 32'h4000_0000);

      // randomized commands with random grant
      gnt_mode = 1;
      for (int t = 0; t < 8; t++) begin
         rf  = 3'($urandom_range(0, 1));
         rs  = 4'(1 << $urandom_range(0, 3));
         rsz = 13'($urandom_range(0, 80));
         ra  = $urandom;
         snap();
         issue(rf, rs, rsz, ra);
         wait_done(1000);
         check_cmd("random", rf, rs, rsz, ra);
      end
      gnt_mode = 0;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
